// File: rtl/ttt_main.sv
// ttt_main: token-threshold-time processor array.
//
// Each processor keeps a signed token counter, an unsigned firing threshold
// and a firing duration. A processor fires once its tokens reach its
// threshold. It then stays active for duration+1 steps, and its start/stop
// events are streamed out. Weighted connections carry the events to other
// processors: a start adds the connection weight to the target, and a stop
// takes it back.
//
// Ports:
//   clock_fast        : single clock, rising edge
//   reset             : asynchronous, active-low, clears all state
//   instruction[3:0]  : HALT/RUN/programming operation select
//   stage[1:0]        : current stage of the RUN step
//   good_tokens_in    : signed excitatory tokens (applied in stage 0)
//   bad_tokens_in     : signed inhibitory tokens (applied in stage 0)
//   processor_id_in   : target processor for input and programming
//   processor_id_out  : processor of the last output event
//   token_startstop   : 01 = start, 10 = stop, 00 = no event
//   output_valid      : one-cycle event strobe
//   connection_id_in  : connection slot for programming
//   prog_tokens       : signed connection weight
//   prog_threshold    : threshold value
//   prog_duration     : duration value
module ttt_main #(
  parameter int NUM_PROCESSORS  = 10,
  parameter int NUM_CONNECTIONS = 50,
  parameter int NEW_TOKEN_BITS  = 4,
  parameter int TOKEN_BITS      = 8,
  parameter int DURATION_BITS   = 8,
  localparam int PID_W = $clog2(NUM_PROCESSORS),
  localparam int CID_W = $clog2(NUM_CONNECTIONS)
) (
  input  logic                             clock_fast,
  input  logic                             reset,
  input  logic [3:0]                       instruction,
  output logic [1:0]                       stage,
  input  logic signed [NEW_TOKEN_BITS-1:0] good_tokens_in,
  input  logic signed [NEW_TOKEN_BITS-1:0] bad_tokens_in,
  input  logic [PID_W-1:0]                 processor_id_in,
  output logic [PID_W-1:0]                 processor_id_out,
  output logic [1:0]                       token_startstop,
  output logic                             output_valid,
  input  logic [CID_W-1:0]                 connection_id_in,
  input  logic signed [NEW_TOKEN_BITS-1:0] prog_tokens,
  input  logic [TOKEN_BITS-1:0]            prog_threshold,
  input  logic [DURATION_BITS-1:0]         prog_duration
);

  localparam logic [3:0] OP_RUN          = 4'b0001;
  localparam logic [3:0] OP_SET_DURATION = 4'b0010;
  localparam logic [3:0] OP_SET_THRESH   = 4'b0011;
  localparam logic [3:0] OP_SET_CONN_SRC = 4'b0100;
  localparam logic [3:0] OP_SET_CONN_TGT = 4'b0101;
  localparam logic [3:0] OP_CLEAR_CONN   = 4'b0110;
  localparam logic [3:0] OP_CLEAR_STATE  = 4'b0111;

  localparam logic [1:0] EV_NONE  = 2'b00;
  localparam logic [1:0] EV_START = 2'b01;
  localparam logic [1:0] EV_STOP  = 2'b10;

  // The scan index is shared by the processor and the connection scans,
  // so it is sized for the longer of the two.
  localparam int SCAN_MAX = (NUM_PROCESSORS > NUM_CONNECTIONS) ? NUM_PROCESSORS : NUM_CONNECTIONS;
  localparam int IDX_W    = $clog2(SCAN_MAX);
  localparam logic [IDX_W-1:0] LAST_PROC = IDX_W'(NUM_PROCESSORS - 1);
  localparam logic [IDX_W-1:0] LAST_CONN = IDX_W'(NUM_CONNECTIONS - 1);

  // Saturation bounds. They are two bits wider than a token so that any
  // token plus any delta fits without overflow before clamping.
  localparam logic signed [TOKEN_BITS+1:0] SAT_MAX = $signed({3'b000, {(TOKEN_BITS-1){1'b1}}});
  localparam logic signed [TOKEN_BITS+1:0] SAT_MIN = $signed({3'b111, {(TOKEN_BITS-1){1'b0}}});

  typedef enum logic [1:0] {
    STAGE_INPUT = 2'd0,
    STAGE_SCAN  = 2'd1,
    STAGE_CONN  = 2'd2,
    STAGE_IDLE  = 2'd3
  } stage_t;

  stage_t           stage_q, stage_d;
  logic [IDX_W-1:0] idx_q, idx_d;

  logic signed [TOKEN_BITS-1:0] tokens    [NUM_PROCESSORS];
  logic [TOKEN_BITS-1:0]        threshold [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0]     duration  [NUM_PROCESSORS];
  logic [DURATION_BITS-1:0]     timer     [NUM_PROCESSORS];
  logic                         active    [NUM_PROCESSORS];
  logic                         started   [NUM_PROCESSORS];
  logic                         stopped   [NUM_PROCESSORS];

  logic [PID_W-1:0]                 conn_src    [NUM_CONNECTIONS];
  logic [PID_W-1:0]                 conn_tgt    [NUM_CONNECTIONS];
  logic signed [NEW_TOKEN_BITS-1:0] conn_weight [NUM_CONNECTIONS];
  logic                             conn_valid  [NUM_CONNECTIONS];

  logic                            run_op;
  logic                            pid_ok;
  logic                            cid_ok;
  logic                            do_input;
  logic                            do_scan;
  logic                            do_conn;
  logic signed [NEW_TOKEN_BITS:0]  diff_in;
  logic [PID_W-1:0]                scan_pid;
  logic signed [TOKEN_BITS:0]      scan_tok_ext;
  logic signed [TOKEN_BITS:0]      scan_thr_ext;
  logic                            scan_fire;
  logic [CID_W-1:0]                scan_cid;
  logic [PID_W-1:0]                cur_src;
  logic [PID_W-1:0]                cur_tgt;
  logic signed [NEW_TOKEN_BITS:0]  weight_ext;
  logic signed [NEW_TOKEN_BITS:0]  weight_neg;
  logic signed [NEW_TOKEN_BITS:0]  conn_delta;
  logic                            conn_hit;

  // Adds a small signed delta to a token count and clamps the result to
  // the signed token range.
  function automatic logic signed [TOKEN_BITS-1:0] sat_add(
    input logic signed [TOKEN_BITS-1:0]   base,
    input logic signed [NEW_TOKEN_BITS:0] delta
  );
    logic signed [TOKEN_BITS+1:0] sum;
    sum = $signed({{2{base[TOKEN_BITS-1]}}, base})
        + $signed({{(TOKEN_BITS+1-NEW_TOKEN_BITS){delta[NEW_TOKEN_BITS]}}, delta});
    if (sum > SAT_MAX) begin
      sat_add = SAT_MAX[TOKEN_BITS-1:0];
    end else if (sum < SAT_MIN) begin
      sat_add = SAT_MIN[TOKEN_BITS-1:0];
    end else begin
      sat_add = sum[TOKEN_BITS-1:0];
    end
  endfunction

  assign run_op = (instruction == OP_RUN);
  assign pid_ok = (processor_id_in <= PID_W'(NUM_PROCESSORS - 1));
  assign cid_ok = (connection_id_in <= CID_W'(NUM_CONNECTIONS - 1));

  // The difference is taken one bit wider than the inputs, so that
  // -8 - 7 does not wrap.
  assign diff_in = {good_tokens_in[NEW_TOKEN_BITS-1], good_tokens_in}
                 - {bad_tokens_in[NEW_TOKEN_BITS-1], bad_tokens_in};

  // Fire test: the threshold is zero-extended, so negative tokens never fire.
  assign scan_pid     = idx_q[PID_W-1:0];
  assign scan_tok_ext = {tokens[scan_pid][TOKEN_BITS-1], tokens[scan_pid]};
  assign scan_thr_ext = {1'b0, threshold[scan_pid]};
  assign scan_fire    = (scan_tok_ext >= scan_thr_ext);

  // Connection propagation: a start adds the weight and a stop removes it.
  // A single scan cannot set both flags for the same processor.
  assign scan_cid   = idx_q[CID_W-1:0];
  assign cur_src    = conn_src[scan_cid];
  assign cur_tgt    = conn_tgt[scan_cid];
  assign weight_ext = {conn_weight[scan_cid][NEW_TOKEN_BITS-1], conn_weight[scan_cid]};
  assign weight_neg = -weight_ext;
  assign conn_hit   = conn_valid[scan_cid] && (started[cur_src] || stopped[cur_src]);
  assign conn_delta = started[cur_src] ? weight_ext : weight_neg;

  // Stage/scan-index state register.
  always_ff @(posedge clock_fast or negedge reset) begin
    if (!reset) begin
      stage_q <= STAGE_INPUT;
      idx_q   <= '0;
    end else begin
      stage_q <= stage_d;
      idx_q   <= idx_d;
    end
  end

  // Next-state logic. Any instruction other than RUN aborts the step and
  // parks the sequencer at stage 0.
  always_comb begin
    stage_d = stage_q;
    idx_d   = idx_q;
    if (!run_op) begin
      stage_d = STAGE_INPUT;
      idx_d   = '0;
    end else begin
      case (stage_q)
        STAGE_INPUT: begin
          stage_d = STAGE_SCAN;
          idx_d   = '0;
        end
        STAGE_SCAN: begin
          if (idx_q == LAST_PROC) begin
            stage_d = STAGE_CONN;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        STAGE_CONN: begin
          if (idx_q == LAST_CONN) begin
            stage_d = STAGE_IDLE;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + 1'b1;
          end
        end
        default: begin
          stage_d = STAGE_INPUT;
          idx_d   = '0;
        end
      endcase
    end
  end

  // Output decode: the stage output and the per-stage work enables.
  always_comb begin
    stage    = stage_q;
    do_input = 1'b0;
    do_scan  = 1'b0;
    do_conn  = 1'b0;
    if (run_op) begin
      case (stage_q)
        STAGE_INPUT: do_input = 1'b1;
        STAGE_SCAN:  do_scan  = 1'b1;
        STAGE_CONN:  do_conn  = 1'b1;
        default:     ;
      endcase
    end
  end

  // Processor and connection state, programming, and the registered
  // event output. Programming happens only outside RUN, and each RUN
  // stage writes tokens in a different cycle, so the writes never collide.
  always_ff @(posedge clock_fast or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_PROCESSORS; i++) begin
        tokens[i]    <= '0;
        threshold[i] <= '0;
        duration[i]  <= '0;
        timer[i]     <= '0;
        active[i]    <= 1'b0;
        started[i]   <= 1'b0;
        stopped[i]   <= 1'b0;
      end
      for (int c = 0; c < NUM_CONNECTIONS; c++) begin
        conn_src[c]    <= '0;
        conn_tgt[c]    <= '0;
        conn_weight[c] <= '0;
        conn_valid[c]  <= 1'b0;
      end
      output_valid     <= 1'b0;
      token_startstop  <= EV_NONE;
      processor_id_out <= '0;
    end else begin
      output_valid    <= 1'b0;
      token_startstop <= EV_NONE;

      if (!run_op) begin
        for (int i = 0; i < NUM_PROCESSORS; i++) begin
          started[i] <= 1'b0;
          stopped[i] <= 1'b0;
        end
      end

      case (instruction)
        OP_SET_DURATION: if (pid_ok) duration[processor_id_in] <= prog_duration;
        OP_SET_THRESH:   if (pid_ok) threshold[processor_id_in] <= prog_threshold;
        OP_SET_CONN_SRC: if (pid_ok && cid_ok) conn_src[connection_id_in] <= processor_id_in;
        OP_SET_CONN_TGT: begin
          if (pid_ok && cid_ok) begin
            conn_tgt[connection_id_in]    <= processor_id_in;
            conn_weight[connection_id_in] <= prog_tokens;
            conn_valid[connection_id_in]  <= 1'b1;
          end
        end
        OP_CLEAR_CONN:   if (cid_ok) conn_valid[connection_id_in] <= 1'b0;
        OP_CLEAR_STATE: begin
          for (int i = 0; i < NUM_PROCESSORS; i++) begin
            tokens[i]  <= '0;
            timer[i]   <= '0;
            active[i]  <= 1'b0;
            started[i] <= 1'b0;
            stopped[i] <= 1'b0;
          end
        end
        default: ;
      endcase

      if (do_input && pid_ok) begin
        tokens[processor_id_in] <= sat_add(tokens[processor_id_in], diff_in);
      end

      // A processor that stops in this scan is not retested for firing
      // until the next step.
      if (do_scan) begin
        started[scan_pid] <= 1'b0;
        stopped[scan_pid] <= 1'b0;
        if (!active[scan_pid]) begin
          if (scan_fire) begin
            active[scan_pid]  <= 1'b1;
            timer[scan_pid]   <= duration[scan_pid];
            started[scan_pid] <= 1'b1;
            output_valid      <= 1'b1;
            token_startstop   <= EV_START;
            processor_id_out  <= scan_pid;
          end
        end else if (timer[scan_pid] != '0) begin
          timer[scan_pid] <= timer[scan_pid] - 1'b1;
        end else begin
          active[scan_pid]  <= 1'b0;
          stopped[scan_pid] <= 1'b1;
          output_valid      <= 1'b1;
          token_startstop   <= EV_STOP;
          processor_id_out  <= scan_pid;
        end
      end

      if (do_conn && conn_hit) begin
        tokens[cur_tgt] <= sat_add(tokens[cur_tgt], conn_delta);
      end
    end
  end

endmodule

// File: tb/tb_ttt_main.sv
// tb_ttt_main: directed testbench for ttt_main.
//
// A step is driven with RUN for its full length, and every event strobe
// seen during the step is recorded. Each event is encoded as
// cycle*256 + id*4 + startstop, where cycle is the sample index inside the
// step. Processor i is scanned on the (i+2)-th edge of the step, so its
// event shows up at sample index i+1.
module tb_ttt_main;

  localparam int NP          = 10;
  localparam int NC          = 50;
  localparam int STEP_CYCLES = NP + NC + 2;

  localparam logic [3:0] OP_HALT         = 4'b0000;
  localparam logic [3:0] OP_RUN          = 4'b0001;
  localparam logic [3:0] OP_SET_DURATION = 4'b0010;
  localparam logic [3:0] OP_SET_THRESH   = 4'b0011;
  localparam logic [3:0] OP_SET_CONN_SRC = 4'b0100;
  localparam logic [3:0] OP_SET_CONN_TGT = 4'b0101;
  localparam logic [3:0] OP_CLEAR_CONN   = 4'b0110;
  localparam logic [3:0] OP_CLEAR_STATE  = 4'b0111;

  logic              clock_fast = 1'b0;
  logic              reset      = 1'b1;
  logic [3:0]        instruction;
  logic [1:0]        stage;
  logic signed [3:0] good_tokens_in;
  logic signed [3:0] bad_tokens_in;
  logic [3:0]        processor_id_in;
  logic [3:0]        processor_id_out;
  logic [1:0]        token_startstop;
  logic              output_valid;
  logic [5:0]        connection_id_in;
  logic signed [3:0] prog_tokens;
  logic [7:0]        prog_threshold;
  logic [7:0]        prog_duration;

  int n_compared   = 0;
  int n_mismatched = 0;
  int ev_q[$];

  ttt_main dut (
    .clock_fast       (clock_fast),
    .reset            (reset),
    .instruction      (instruction),
    .stage            (stage),
    .good_tokens_in   (good_tokens_in),
    .bad_tokens_in    (bad_tokens_in),
    .processor_id_in  (processor_id_in),
    .processor_id_out (processor_id_out),
    .token_startstop  (token_startstop),
    .output_valid     (output_valid),
    .connection_id_in (connection_id_in),
    .prog_tokens      (prog_tokens),
    .prog_threshold   (prog_threshold),
    .prog_duration    (prog_duration)
  );

  always #5 clock_fast = ~clock_fast;

  function automatic int ev_code(input int k, input int id, input int ss);
    return k * 256 + id * 4 + ss;
  endfunction

  task automatic check_output(input string tag, input int actual, input int expected);
    n_compared++;
    assert (actual === expected) else begin
      n_mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, actual, expected);
    end
  endtask

  // One programming cycle, issued from a falling edge.
  task automatic apply_stimulus(input logic [3:0] op, input int pid, input int cid,
                                input int ptok, input int thr, input int dur);
    instruction      = op;
    processor_id_in  = 4'(pid);
    connection_id_in = 6'(cid);
    prog_tokens      = 4'(ptok);
    prog_threshold   = 8'(thr);
    prog_duration    = 8'(dur);
    @(posedge clock_fast);
    @(negedge clock_fast);
    instruction = OP_HALT;
  endtask

  task automatic run_step(input int pid, input int good, input int bad);
    ev_q.delete();
    instruction     = OP_RUN;
    processor_id_in = 4'(pid);
    good_tokens_in  = 4'(good);
    bad_tokens_in   = 4'(bad);
    for (int k = 0; k < STEP_CYCLES; k++) begin
      @(posedge clock_fast);
      @(negedge clock_fast);
      if (output_valid) ev_q.push_back(ev_code(k, int'(processor_id_out), int'(token_startstop)));
    end
    instruction = OP_HALT;
    check_output("stage at step end", int'(stage), 0);
  endtask

  task automatic check_step(input string tag, input int n, input int e0, input int e1);
    check_output({tag, " count"}, ev_q.size(), n);
    if (n >= 1) check_output({tag, " ev0"}, (ev_q.size() > 0) ? ev_q[0] : -1, e0);
    if (n >= 2) check_output({tag, " ev1"}, (ev_q.size() > 1) ? ev_q[1] : -1, e1);
  endtask

  initial begin
    instruction      = OP_HALT;
    good_tokens_in   = '0;
    bad_tokens_in    = '0;
    processor_id_in  = '0;
    connection_id_in = '0;
    prog_tokens      = '0;
    prog_threshold   = '0;
    prog_duration    = '0;

    // Reset values
    #3 reset = 1'b0;
    #1;
    check_output("reset stage", int'(stage), 0);
    check_output("reset valid", int'(output_valid), 0);
    check_output("reset startstop", int'(token_startstop), 0);
    check_output("reset id_out", int'(processor_id_out), 0);
    repeat (2) @(negedge clock_fast);
    reset = 1'b1;
    @(negedge clock_fast);

    // Keep every processor quiet unless a test arms it
    for (int i = 0; i < NP; i++) apply_stimulus(OP_SET_THRESH, i, 0, 0, 100, 0);

    // An out-of-range processor id must be ignored
    apply_stimulus(OP_SET_THRESH, 12, 0, 0, 0, 0);
    run_step(12, 7, 0);
    check_step("pid12 step1", 0, 0, 0);
    run_step(12, 7, 0);
    check_step("pid12 step2", 0, 0, 0);

    // Proc 3 drives proc 4 through connection 0
    apply_stimulus(OP_SET_THRESH, 3, 0, 0, 5, 0);
    apply_stimulus(OP_SET_DURATION, 3, 0, 0, 0, 2);
    apply_stimulus(OP_SET_CONN_SRC, 3, 0, 0, 0, 0);
    apply_stimulus(OP_SET_CONN_TGT, 4, 0, 4, 0, 0);
    apply_stimulus(OP_SET_THRESH, 4, 0, 0, 4, 0);
    run_step(3, 3, 0);
    check_step("chain step1", 0, 0, 0);
    run_step(3, 3, 0);
    check_step("chain step2", 1, ev_code(4, 3, 1), 0);
    run_step(15, 0, 0);
    check_step("chain step3", 1, ev_code(5, 4, 1), 0);
    run_step(15, 0, 0);
    check_step("chain step4", 1, ev_code(5, 4, 2), 0);
    run_step(15, 0, 0);
    check_step("chain step5", 2, ev_code(4, 3, 2), ev_code(5, 4, 1));
    apply_stimulus(OP_SET_THRESH, 3, 0, 0, 127, 0);
    run_step(15, 0, 0);
    check_step("chain step6", 1, ev_code(5, 4, 2), 0);
    run_step(15, 0, 0);
    check_step("chain step7", 0, 0, 0);
    run_step(15, 0, 0);
    check_step("chain step8", 0, 0, 0);

    // HALT in the middle of stage 2, then CLEAR_STATE
    apply_stimulus(OP_SET_THRESH, 3, 0, 0, 5, 0);
    instruction     = OP_RUN;
    processor_id_in = 4'd15;
    good_tokens_in  = '0;
    bad_tokens_in   = '0;
    repeat (20) begin
      @(posedge clock_fast);
      @(negedge clock_fast);
    end
    check_output("mid-step stage", int'(stage), 2);
    instruction = OP_HALT;
    @(posedge clock_fast);
    @(negedge clock_fast);
    check_output("halt stage", int'(stage), 0);
    check_output("halt valid", int'(output_valid), 0);
    apply_stimulus(OP_CLEAR_STATE, 0, 0, 0, 0, 0);
    run_step(15, 0, 0);
    check_step("cleared step1", 0, 0, 0);
    run_step(15, 0, 0);
    check_step("cleared step2", 0, 0, 0);
    apply_stimulus(OP_CLEAR_CONN, 0, 0, 0, 0, 0);

    // Positive saturation: 7 per step reaches 127 only on step 19
    apply_stimulus(OP_SET_THRESH, 1, 0, 0, 127, 0);
    apply_stimulus(OP_SET_DURATION, 1, 0, 0, 0, 200);
    apply_stimulus(OP_CLEAR_STATE, 0, 0, 0, 0, 0);
    for (int s = 1; s <= 18; s++) begin
      run_step(1, 7, 0);
      check_step($sformatf("satpos step%0d", s), 0, 0, 0);
    end
    run_step(1, 7, 0);
    check_step("satpos step19", 1, ev_code(2, 1, 1), 0);
    run_step(1, 7, 0);
    check_step("satpos step20", 0, 0, 0);

    // Negative saturation with a zero threshold: negative tokens never fire
    apply_stimulus(OP_CLEAR_STATE, 0, 0, 0, 0, 0);
    apply_stimulus(OP_SET_THRESH, 1, 0, 0, 0, 0);
    apply_stimulus(OP_SET_DURATION, 1, 0, 0, 0, 0);
    for (int s = 1; s <= 20; s++) begin
      run_step(1, -8, 7);
      check_step($sformatf("satneg15 step%0d", s), 0, 0, 0);
    end
    for (int s = 1; s <= 20; s++) begin
      run_step(1, 0, 7);
      check_step($sformatf("satneg7 step%0d", s), 0, 0, 0);
    end
    // From -128, 7 per step first reaches >= 0 on step 19
    for (int s = 1; s <= 18; s++) begin
      run_step(1, 7, 0);
      check_step($sformatf("recover step%0d", s), 0, 0, 0);
    end
    run_step(1, 7, 0);
    check_step("recover step19", 1, ev_code(2, 1, 1), 0);

    // Reset asserted mid-RUN, just after proc 1's stop event
    instruction     = OP_RUN;
    processor_id_in = 4'd15;
    good_tokens_in  = '0;
    bad_tokens_in   = '0;
    repeat (3) @(posedge clock_fast);
    #1;
    check_output("pre-reset valid", int'(output_valid), 1);
    check_output("pre-reset startstop", int'(token_startstop), 2);
    check_output("pre-reset id_out", int'(processor_id_out), 1);
    #1 reset = 1'b0;
    #1;
    check_output("async reset stage", int'(stage), 0);
    check_output("async reset valid", int'(output_valid), 0);
    check_output("async reset startstop", int'(token_startstop), 0);
    check_output("async reset id_out", int'(processor_id_out), 0);
    @(negedge clock_fast);
    instruction = OP_HALT;
    @(negedge clock_fast);
    reset = 1'b1;
    @(negedge clock_fast);

    // Thresholds are cleared, so every processor fires in index order
    run_step(15, 0, 0);
    check_output("post-reset fire count", ev_q.size(), NP);
    for (int i = 0; i < NP; i++) begin
      check_output($sformatf("post-reset start %0d", i),
                   (ev_q.size() > i) ? ev_q[i] : -1, ev_code(i + 1, i, 1));
    end
    for (int i = 0; i < NP; i++) apply_stimulus(OP_SET_THRESH, i, 0, 0, 1, 0);
    run_step(15, 0, 0);
    check_output("post-reset stop count", ev_q.size(), NP);
    for (int i = 0; i < NP; i++) begin
      check_output($sformatf("post-reset stop %0d", i),
                   (ev_q.size() > i) ? ev_q[i] : -1, ev_code(i + 1, i, 2));
    end
    run_step(15, 0, 0);
    check_step("post-reset tokens zero", 0, 0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
